// File: rtl/mips_pkg.sv
// ============================================================================
// Module  : mips_pkg
// Brief   : Shared MIPS instruction field positions and extension encodings.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int IDX_HI = 25;
  localparam int IDX_LO = 0;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

endpackage

`default_nettype wire

// File: rtl/instr_field_decode.sv
// ============================================================================
// Module  : instr_field_decode
// Brief   : Combinational split of an instruction word plus immediate and
//           branch/jump target computation.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_field_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [1:0]  ext_op,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  func,
  output logic [15:0] imm,
  output logic [25:0] index,
  output logic [31:0] imm_ext,
  output logic [31:0] br_target,
  output logic [31:0] j_target
);

  logic [31:0] w_pc_plus4;
  logic [31:0] w_imm_sext;

  assign opcode = instr[OPC_HI:OPC_LO];
  assign rs     = instr[RS_HI:RS_LO];
  assign rt     = instr[RT_HI:RT_LO];
  assign rd     = instr[RD_HI:RD_LO];
  assign shamt  = instr[SH_HI:SH_LO];
  assign func   = instr[FN_HI:FN_LO];
  assign imm    = instr[IMM_HI:IMM_LO];
  assign index  = instr[IDX_HI:IDX_LO];

  assign w_pc_plus4 = pc + 32'd4;
  assign w_imm_sext = {{16{imm[15]}}, imm};

  // Branch offset is always sign-extended, independent of ext_op.
  assign br_target = w_pc_plus4 + (w_imm_sext << 2);
  assign j_target  = {w_pc_plus4[31:28], index, 2'b00};

  always_comb begin
    imm_ext = {16'h0000, imm};
    case (ext_op)
      EXT_SIGN: imm_ext = w_imm_sext;
      EXT_LUI:  imm_ext = {imm, 16'h0000};
      default:  imm_ext = {16'h0000, imm};
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_queue.sv
// ============================================================================
// Module  : instr_fetch_queue
// Brief   : IF->D prefetch FIFO holding instruction/PC pairs; head entry is
//           presented pre-decoded.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch_queue
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic [1:0]                 ext_op,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  output logic [5:0]                 out_opcode,
  output logic [4:0]                 out_rs,
  output logic [4:0]                 out_rt,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_shamt,
  output logic [5:0]                 out_func,
  output logic [15:0]                out_imm,
  output logic [25:0]                out_index,
  output logic [31:0]                out_imm_ext,
  output logic [31:0]                out_br_target,
  output logic [31:0]                out_j_target,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   r_instr_mem [DEPTH];
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign in_ready  = (r_count < DEPTH_C);
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an empty queue masks the head with a nop.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_instr_mem[r_wr_ptr] <= in_instr;
      r_pc_mem[r_wr_ptr]    <= in_pc;
    end
  end

  assign out_instr = out_valid ? r_instr_mem[r_rd_ptr] : 32'h0000_0000;
  assign out_pc    = out_valid ? r_pc_mem[r_rd_ptr]    : PC_RESET;

  instr_field_decode u_decode (
    .instr     (out_instr),
    .pc        (out_pc),
    .ext_op    (ext_op),
    .opcode    (out_opcode),
    .rs        (out_rs),
    .rt        (out_rt),
    .rd        (out_rd),
    .shamt     (out_shamt),
    .func      (out_func),
    .imm       (out_imm),
    .index     (out_index),
    .imm_ext   (out_imm_ext),
    .br_target (out_br_target),
    .j_target  (out_j_target)
  );

endmodule

`default_nettype wire

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Parametrised prefetch queue between the IF stage and the D stage of the pipelined MIPS core.
- Buffers fetched instruction words together with their PCs in a circular FIFO.
- Presents the head entry already split into opcode, rs, rt, rd, shamt, func, imm and index fields.
- Also presents the extended immediate, the branch target and the jump target, so D-stage decode does no field slicing.
- Valid/ready handshake on both sides; synchronous flush for taken branches and jumps.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- PC_RESET, 32'h0000_3000, PC value presented on out_pc while the queue is empty.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all entries.
- in_valid  input  1  IF offers an instruction this cycle.
- in_ready  output  1  queue accepts the offer this cycle.
- in_instr  input  32  fetched instruction word.
- in_pc  input  32  PC of in_instr.
- out_valid  output  1  head entry valid.
- out_ready  input  1  D stage consumes the head this cycle.
- ext_op  input  2  immediate extension mode: 0 zero-extend, 1 sign-extend, 2 load-upper ({imm,16'b0}), 3 reserved (behaves as 0).
- out_instr  output  32  head instruction word.
- out_pc  output  32  head PC.
- out_opcode  output  6  instr[31:26].
- out_rs  output  5  instr[25:21].
- out_rt  output  5  instr[20:16].
- out_rd  output  5  instr[15:11].
- out_shamt  output  5  instr[10:6].
- out_func  output  6  instr[5:0].
- out_imm  output  16  instr[15:0].
- out_index  output  26  instr[25:0].
- out_imm_ext  output  32  imm extended per ext_op.
- out_br_target  output  32  pc+4 + (sign-extended imm << 2), modulo 2^32.
- out_j_target  output  32  {pc_plus4[31:28], index, 2'b00}.
- count  output  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset:
  - Asynchronous; takes effect immediately on assertion, mid-operation included.
  - wr_ptr=0, rd_ptr=0, count=0, out_valid=0.
  - Storage contents are don't-care.
- Readiness and status:
  - in_ready = (count < DEPTH). No same-cycle pass-through when full, so in_ready never depends on out_ready.
  - out_valid = (count != 0).
- Transfers:
  - Push when in_valid && in_ready: entry written at wr_ptr, wr_ptr increments modulo DEPTH.
  - Pop when out_valid && out_ready: rd_ptr increments modulo DEPTH.
  - Simultaneous push and pop: count unchanged; both pointers advance.
- Latency:
  - An instruction pushed into an empty queue appears on the outputs, with out_valid=1, in the following cycle.
  - Output fields are combinational from the head storage entry; there is no additional register stage.
- Empty queue:
  - out_instr=0 (nop); all split fields, out_imm_ext, out_br_target and out_j_target are derived from that 0 word.
  - out_pc=PC_RESET.
- Full queue: in_ready=0; a pop in that cycle frees a slot for the next cycle only.
- Flush:
  - Synchronous; highest priority over push and pop in the same cycle.
  - Next state: count=0, wr_ptr=rd_ptr=0, out_valid=0.
  - An offered instruction in the flush cycle is dropped, even though in_ready may read 1.
- Pointer wrap-around: pointers are $clog2(DEPTH) bits wide and wrap naturally; count distinguishes full from empty.
- Arithmetic:
  - pc_plus4 = out_pc + 32'd4, with overflow wrap.
  - out_br_target uses the 32-bit sign-extended imm shifted left 2 regardless of ext_op.
- Protocol: in_instr and in_pc are sampled only on the push edge; once out_valid=1 the head entry stays stable until it is popped or flushed.

Decomposition:
- Shared package (mips_pkg):
  - Field bit positions: OPC_HI/LO, RS_HI/LO, RT_HI/LO, RD_HI/LO, SH_HI/LO, FN_HI/LO.
  - ext_op encodings EXT_ZERO, EXT_SIGN, EXT_LUI.
  - PC_RESET default.
- Sub-module instr_field_decode: purely combinational.
  - Inputs: instr, pc, ext_op.
  - Outputs: all split fields, imm_ext, br_target, j_target.
- The queue itself holds only storage, pointers, count and flush logic, and instantiates instr_field_decode once on the head entry.

Test Plan:
- Reset then idle: out_valid=0, count=0, in_ready=1, out_pc=32'h3000, out_instr=0, out_j_target=32'h0.
- Push one word, instr=32'h8C28_FFFC at pc=32'h3004, ext_op=1 -> next cycle:
  - out_valid=1, opcode=6'h23, rs=1, rt=8.
  - out_imm_ext=32'hFFFF_FFFC, out_br_target=32'h2FF8.
- Push 32'h0800_0C10 at pc=32'h3008 -> out_j_target=32'h0000_3040. With ext_op=2 on 32'h3C01_1234 -> out_imm_ext=32'h1234_0000.
- Push DEPTH words with out_ready=0:
  - count=DEPTH, in_ready=0; a further offer is not accepted.
  - Then pop continuously: words emerge in push order across pointer wrap, one per cycle.
- Steady stream, push and pop every cycle at count=2 -> count stays 2; output order preserved over 3*DEPTH words.
- Flush with count=3 and in_valid=1 -> next cycle count=0, out_valid=0, offered word absent.
- Reset asserted mid-stream, off-edge -> outputs clear immediately without waiting for clk.
